// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave interface.
// Optional build macro: SPI_SLAVE_MISO_TRI_EN (tri-states MISO outside a frame).
package spi_slave_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } spi_st_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Leading edge: SCK leaves its idle level.
  function automatic logic lead_edge(input logic prev, input logic cur, input logic active);
    return (prev == active) && (cur != active);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection for one asynchronous SPI pin.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      valid_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until both compared samples come from the pin, not reset,
  // so a line already low at reset release never reports a falling edge.
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign prev_o = prev_q;
  assign rise_o = valid_q[SYNC_STAGES] &  q_o & ~prev_q;
  assign fall_o = valid_q[SYNC_STAGES] & ~q_o &  prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: oversampled pins, MOSI deserialiser, handshaked MISO serialiser.
// Optional build macro: SPI_SLAVE_MISO_TRI_EN (MISO high-Z while no frame is active).
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int unsigned PHASE  = 0,
  parameter int unsigned ACTIVE = 0,
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_vld,
  output logic             rx_first,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_vld,
  output logic             tx_rdy,
  output logic             tx_underrun,
  output logic             frame_active,
  output logic             frame_end,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int unsigned BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BW-1:0] LAST = BW'(DSIZE - 1);
  localparam logic ACT_LVL = (ACTIVE != 0);

  logic cs_s, cs_prev, cs_rise, cs_fall;
  logic sck_s, sck_prev, sck_rise, sck_fall;
  logic mosi_s, mosi_prev, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clock), .rst_n_i(rst_n), .d_i(cs_n),
    .q_o(cs_s), .prev_o(cs_prev), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(ACT_LVL)) u_sync_sck (
    .clk_i(clock), .rst_n_i(rst_n), .d_i(sck),
    .q_o(sck_s), .prev_o(sck_prev), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clock), .rst_n_i(rst_n), .d_i(mosi),
    .q_o(mosi_s), .prev_o(mosi_prev), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );
  assign unused_edges = ^{cs_s, cs_prev, sck_rise, sck_fall, mosi_prev, mosi_rise, mosi_fall};

  logic lead, trail, sample_edge, shift_edge;
  assign lead        = lead_edge(sck_prev, sck_s, ACT_LVL);
  assign trail       = lead_edge(sck_prev, sck_s, ~ACT_LVL);
  assign sample_edge = (PHASE == 0) ? lead : trail;
  assign shift_edge  = (PHASE == 0) ? trail : lead;

  spi_st_e          state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DSIZE-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DSIZE-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             rx_vld_q, rx_vld_d, rx_first_q, rx_first_d;
  logic             tx_underrun_q, tx_underrun_d, frame_end_q, frame_end_d;
  logic             load;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_vld_d      = 1'b0;
    rx_first_d    = rx_first_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_underrun_d = 1'b0;
    frame_end_d   = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = FRAME;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          load       = (PHASE == 0);
        end
      end
      FRAME: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = '0;
          tx_shift_d  = '1;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DSIZE-2:0], mosi_s};
            if (bit_cnt_q == LAST) begin
              bit_cnt_d  = '0;
              rx_data_d  = {rx_shift_q[DSIZE-2:0], mosi_s};
              rx_vld_d   = 1'b1;
              rx_first_d = (byte_cnt_q == '0);
              if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if (bit_cnt_q == '0) load = 1'b1;
            else tx_shift_d = {tx_shift_q[DSIZE-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A write coinciding with a load on an empty holding register bypasses it.
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_vld) begin
        tx_shift_d = tx_data;
      end else begin
        tx_shift_d    = '1;
        tx_underrun_d = 1'b1;
      end
    end else if (tx_vld && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_vld_q      <= 1'b0;
      rx_first_q    <= 1'b0;
      tx_shift_q    <= '1;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_vld_q      <= rx_vld_d;
      rx_first_q    <= rx_first_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_underrun_q <= tx_underrun_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign frame_active = (state_q == FRAME);
  assign miso_oe      = frame_active;
`ifdef SPI_SLAVE_MISO_TRI_EN
  assign miso = miso_oe ? tx_shift_q[DSIZE-1] : 1'bz;
`else
  assign miso = tx_shift_q[DSIZE-1];
`endif
  assign rx_data     = rx_data_q;
  assign rx_vld      = rx_vld_q;
  assign rx_first    = rx_first_q;
  assign tx_rdy      = ~hold_full_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_end   = frame_end_q;
  assign byte_cnt    = byte_cnt_q;

endmodule
